// File: rtl/axis_out_fifo_if.sv
// Valid/ready beat stream with end-of-frame marker; used for both the
// producer side and the AXI-Stream side of the output FIFO.
interface axis_out_fifo_if #(
  parameter int pDATA_WIDTH = 32
);
  logic [pDATA_WIDTH-1:0] data;
  logic                   valid;
  logic                   last;
  logic                   ready;

  modport master (
    output data,
    output valid,
    output last,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  last,
    output ready
  );
endinterface

// File: rtl/axis_out_fifo.sv
// Small output FIFO: buffers producer beats and presents them as an
// AXI-Stream master, with frame-done pulse and sticky overflow flag.
module axis_out_fifo #(
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH      = 4,
  parameter int pLVL_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  axis_out_fifo_if.slave        fir,
  axis_out_fifo_if.master       axis,
  output logic [pLVL_WIDTH-1:0] level,
  output logic                  outfinish,
  output logic                  drop_err
);
  localparam int lpPTR_W = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;

  typedef logic [pDATA_WIDTH:0] entry_t;

  entry_t                  r_mem [pDEPTH];
  logic [lpPTR_W-1:0]      r_wr_ptr;
  logic [lpPTR_W-1:0]      r_rd_ptr;
  logic [pLVL_WIDTH-1:0]   r_count;
  logic                    r_outfinish;
  logic                    r_drop_err;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  entry_t                  w_head;

  assign w_full  = (r_count == pLVL_WIDTH'(pDEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = fir.valid && !w_full;
  assign w_pop   = !w_empty && axis.ready;
  assign w_head  = r_mem[r_rd_ptr];

  // Storage holds no reset; stale entries are never visible because the
  // outputs are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {fir.last, fir.data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_outfinish <= 1'b0;
      r_drop_err  <= 1'b0;
    end else if (clr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_outfinish <= 1'b0;
      r_drop_err  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + lpPTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + lpPTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + pLVL_WIDTH'(1);
        2'b01:   r_count <= r_count - pLVL_WIDTH'(1);
        default: r_count <= r_count;
      endcase
      r_outfinish <= w_pop && w_head[pDATA_WIDTH];
      if (fir.valid && w_full) begin
        r_drop_err <= 1'b1;
      end
    end
  end

  // Ready and valid come only from the count, so no tready-to-fir_ready path.
  assign fir.ready  = !w_full;
  assign axis.valid = !w_empty;
  assign axis.data  = w_empty ? '0 : w_head[pDATA_WIDTH-1:0];
  assign axis.last  = !w_empty && w_head[pDATA_WIDTH];
  assign level      = r_count;
  assign outfinish  = r_outfinish;
  assign drop_err   = r_drop_err;
endmodule

// File: tb/tb_axis_out_fifo.sv
// Directed vector table plus model-checked stall/wrap and clear/reset sequences.
module tb_axis_out_fifo;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic [2:0] level;
  logic       outfinish;
  logic       drop_err;

  axis_out_fifo_if #(.pDATA_WIDTH(32)) fir_if ();
  axis_out_fifo_if #(.pDATA_WIDTH(32)) axis_if ();

  axis_out_fifo #(
    .pDATA_WIDTH(32),
    .pDEPTH     (4),
    .pLVL_WIDTH (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .fir      (fir_if),
    .axis     (axis_if),
    .level    (level),
    .outfinish(outfinish),
    .drop_err (drop_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [31:0] d;
    logic        lst;
    logic        rdy;
    logic        c;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    int          lvl;
    logic        erdy;
    logic        eof;
    logic        edrop;
  } vec_t;

  vec_t        tbl[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [32:0] mq[$];
  logic        m_of = 1'b0;
  logic        m_drop = 1'b0;
  int          n_out = 0;

  function automatic vec_t mk(input logic vld, input logic [31:0] d, input logic lst,
                              input logic rdy, input logic c, input logic ev,
                              input logic [31:0] ed, input logic el, input int lvl,
                              input logic erdy, input logic eof, input logic edrop);
    vec_t v;
    v.vld = vld; v.d = d; v.lst = lst; v.rdy = rdy; v.c = c;
    v.ev = ev; v.ed = ed; v.el = el; v.lvl = lvl;
    v.erdy = erdy; v.eof = eof; v.edrop = edrop;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [31:0] d, input logic lst,
                       input logic rdy, input logic c);
    fir_if.valid  = vld;
    fir_if.data   = d;
    fir_if.last   = lst;
    axis_if.ready = rdy;
    clr           = c;
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [31:0] ed,
                            input logic el, input int lvl, input logic erdy,
                            input logic eof, input logic edrop);
    check({tag, ".tvalid"},    32'(axis_if.valid), 32'(ev));
    check({tag, ".tdata"},     axis_if.data,       ed);
    check({tag, ".tlast"},     32'(axis_if.last),  32'(el));
    check({tag, ".level"},     32'(level),         32'(lvl));
    check({tag, ".fir_ready"}, 32'(fir_if.ready),  32'(erdy));
    check({tag, ".outfinish"}, 32'(outfinish),     32'(eof));
    check({tag, ".drop_err"},  32'(drop_err),      32'(edrop));
  endtask

  // One cycle against the reference queue model: compare, then advance the model.
  task automatic mstep(input logic vld, input logic [31:0] d, input logic lst,
                       input logic rdy, output logic acc);
    logic [32:0] head;
    logic        mpush;
    logic        mpop;
    @(negedge clk);
    drive(vld, d, lst, rdy, 1'b0);
    head = (mq.size() != 0) ? mq[0] : 33'd0;
    check_outs("model", mq.size() != 0, head[31:0], head[32], mq.size(),
               mq.size() != 4, m_of, m_drop);
    mpush = vld && (mq.size() != 4);
    mpop  = (mq.size() != 0) && rdy;
    m_of  = mpop && head[32];
    if (vld && mq.size() == 4) m_drop = 1'b1;
    if (mpop) begin
      void'(mq.pop_front());
      n_out++;
    end
    if (mpush) mq.push_back({lst, d});
    acc = mpush;
  endtask

  task automatic clear_all();
    @(negedge clk);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    mq.delete();
    m_of   = 1'b0;
    m_drop = 1'b0;
  endtask

  task automatic run_stream(input bit rand_rdy, input string name);
    int   idx = 0;
    int   cyc = 0;
    logic acc;
    logic vld;
    logic rdy;
    n_out = 0;
    while (n_out < 13 && cyc < 500) begin
      vld = (idx < 13) && ($urandom_range(0, 3) != 0);
      rdy = rand_rdy ? 1'($urandom_range(0, 1)) : cyc[0];
      mstep(vld, 32'(32'h100 + idx), idx == 12, rdy, acc);
      if (acc) idx++;
      cyc++;
    end
    check({name, ".beats_out"}, 32'(n_out), 32'd13);
    mstep(1'b0, 32'd0, 1'b0, 1'b0, acc);
    mstep(1'b0, 32'd0, 1'b0, 1'b0, acc);
    $display("%s: %0d beats in %0d cycles", name, n_out, cyc);
    clear_all();
  endtask

  initial begin
    // Streaming 1..8, last on 8
    tbl.push_back(mk(1, 32'h1, 0, 1, 0,  0, 32'h0, 0, 0, 1, 0, 0));
    for (int k = 2; k <= 8; k++)
      tbl.push_back(mk(1, 32'(k), k == 8, 1, 0,  1, 32'(k - 1), 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 32'h0, 0, 1, 0,  1, 32'h8, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 32'h0, 0, 1, 0,  0, 32'h0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 32'h0, 0, 1, 0,  0, 32'h0, 0, 0, 1, 0, 0));
    // Backpressure: six offered, four kept, overflow flagged, then clr
    tbl.push_back(mk(1, 32'hA, 0, 0, 0,  0, 32'h0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 32'hB, 0, 0, 0,  1, 32'hA, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 32'hC, 0, 0, 0,  1, 32'hA, 0, 2, 1, 0, 0));
    tbl.push_back(mk(1, 32'hD, 0, 0, 0,  1, 32'hA, 0, 3, 1, 0, 0));
    tbl.push_back(mk(1, 32'hE, 0, 0, 0,  1, 32'hA, 0, 4, 0, 0, 0));
    tbl.push_back(mk(1, 32'hF, 0, 0, 0,  1, 32'hA, 0, 4, 0, 0, 1));
    tbl.push_back(mk(0, 32'h0, 0, 1, 0,  1, 32'hA, 0, 4, 0, 0, 1));
    tbl.push_back(mk(0, 32'h0, 0, 1, 0,  1, 32'hB, 0, 3, 1, 0, 1));
    tbl.push_back(mk(0, 32'h0, 0, 1, 0,  1, 32'hC, 0, 2, 1, 0, 1));
    tbl.push_back(mk(0, 32'h0, 0, 1, 0,  1, 32'hD, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 32'h0, 0, 0, 0,  0, 32'h0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 32'h0, 0, 0, 1,  0, 32'h0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 32'h0, 0, 0, 0,  0, 32'h0, 0, 0, 1, 0, 0));
    // Full with simultaneous push/pop attempt, then steady level 3
    tbl.push_back(mk(1, 32'h21, 0, 0, 0,  0, 32'h0,  0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 32'h22, 0, 0, 0,  1, 32'h21, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 32'h23, 0, 0, 0,  1, 32'h21, 0, 2, 1, 0, 0));
    tbl.push_back(mk(1, 32'h24, 0, 0, 0,  1, 32'h21, 0, 3, 1, 0, 0));
    tbl.push_back(mk(1, 32'h25, 0, 1, 0,  1, 32'h21, 0, 4, 0, 0, 0));
    tbl.push_back(mk(1, 32'h25, 0, 1, 0,  1, 32'h22, 0, 3, 1, 0, 1));
    tbl.push_back(mk(1, 32'h26, 0, 1, 0,  1, 32'h23, 0, 3, 1, 0, 1));
    tbl.push_back(mk(1, 32'h27, 1, 1, 0,  1, 32'h24, 0, 3, 1, 0, 1));
    tbl.push_back(mk(0, 32'h0,  0, 1, 0,  1, 32'h25, 0, 3, 1, 0, 1));
    tbl.push_back(mk(0, 32'h0,  0, 1, 0,  1, 32'h26, 0, 2, 1, 0, 1));
    tbl.push_back(mk(0, 32'h0,  0, 1, 0,  1, 32'h27, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 32'h0,  0, 0, 1,  0, 32'h0,  0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0,  0, 32'h0,  0, 0, 1, 0, 0));

    rst_n = 1'b0;
    drive(1'b1, 32'hDEAD, 1'b1, 1'b1, 1'b0);
    #1;
    check_outs("reset", 0, 32'h0, 0, 0, 1, 0, 0);
    @(negedge clk);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].vld, tbl[i].d, tbl[i].lst, tbl[i].rdy, tbl[i].c);
      check_outs($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].el, tbl[i].lvl,
                 tbl[i].erdy, tbl[i].eof, tbl[i].edrop);
      $display("vec %0d: valid=%0b data=0x%0h ready=%0b clr=%0b -> tvalid=%0b tdata=0x%0h level=%0d",
               i, tbl[i].vld, tbl[i].d, tbl[i].rdy, tbl[i].c, axis_if.valid, axis_if.data, level);
    end

    // Stall stability with alternating tready, then wrap-around with random tready
    run_stream(1'b0, "toggle_ready");
    run_stream(1'b1, "random_ready");

    // clr mid-frame with push and pop active; head beat carries last
    @(negedge clk); drive(1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
    @(negedge clk); drive(1'b1, 32'h88, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("clr_pre.level", 32'(level), 32'd2);
    drive(1'b1, 32'h99, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    check_outs("clr_post", 0, 32'h0, 0, 0, 1, 0, 0);
    @(negedge clk);
    check("clr_post2.outfinish", 32'(outfinish), 32'd0);
    $display("clr mid-frame: level=%0d tvalid=%0b", level, axis_if.valid);

    // Asynchronous reset mid-frame
    drive(1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
    @(negedge clk); drive(1'b1, 32'h88, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_pre.level", 32'(level), 32'd2);
    drive(1'b1, 32'h99, 1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_outs("rst_async", 0, 32'h0, 0, 0, 1, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h99, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    check_outs("rst_first_push", 1, 32'h99, 0, 1, 1, 0, 0);
    $display("reset mid-frame: level=%0d tdata=0x%0h", level, axis_if.data);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
